// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv control path: FSM state encoding,
// default iteration counts and the operating-mode encoding.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int MULT_STEPS_DEF = 16;
    localparam int DIV_STEPS_DEF  = 32;

    localparam logic MODE_MULT = 1'b0;
    localparam logic MODE_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Control/status bundle between the multdiv sequencer and its datapath.
// slave = sequencer side, master = datapath / requester side.
interface multdiv_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             div_zero;
    logic             mult_ovf;
    logic             load_en;
    logic             step_en;
    logic             mode_div;
    logic [CNT_W-1:0] step_idx;
    logic             busy;
    logic             data_resultRDY;
    logic             data_exception;

    modport slave (
        input  ctrl_MULT, ctrl_DIV, div_zero, mult_ovf,
        output load_en, step_en, mode_div, step_idx, busy,
               data_resultRDY, data_exception
    );

    modport master (
        output ctrl_MULT, ctrl_DIV, div_zero, mult_ovf,
        input  load_en, step_en, mode_div, step_idx, busy,
               data_resultRDY, data_exception
    );
endinterface

// File: rtl/multdiv_step_counter.sv
// Iteration counter: synchronous clear has priority over enable; tc_o flags
// that the current count equals the run-time terminal value.
module multdiv_step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the shared multiply/divide datapath: LOAD, N RUN steps, DONE.
// A new start request in any state aborts the current operation and reloads.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int MULT_STEPS = MULT_STEPS_DEF,
    parameter int DIV_STEPS  = DIV_STEPS_DEF,
    parameter int CNT_W      = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_sequencer_if.slave   bus
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             dz_q, dz_d;
    logic             start;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign limit = (mode_q == MODE_DIV) ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MULT_STEPS - 1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: state_d = IDLE;
            LOAD: begin
                if ((mode_q == MODE_DIV) && bus.div_zero) begin
                    state_d = DONE;
                    dz_d    = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN:  if (cnt_tc) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Start requests abort whatever is in flight; multiply wins a tie.
        if (start) begin
            state_d = LOAD;
            mode_d  = bus.ctrl_MULT ? MODE_MULT : MODE_DIV;
            dz_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_MULT;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dz_q    <= dz_d;
        end
    end

    assign cnt_en  = (state_q == RUN);
    assign cnt_clr = start | (state_q != RUN) | cnt_tc;

    multdiv_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (limit),
        .cnt_o   (cnt),
        .tc_o    (cnt_tc)
    );

    assign bus.load_en        = (state_q == LOAD);
    assign bus.step_en        = (state_q == RUN);
    assign bus.busy           = (state_q == LOAD) || (state_q == RUN);
    assign bus.mode_div       = mode_q;
    assign bus.step_idx       = cnt;
    assign bus.data_resultRDY = (state_q == DONE);
    assign bus.data_exception = (state_q == DONE) &&
                                (dz_q || ((mode_q == MODE_MULT) && bus.mult_ovf));

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.
module tb_multdiv_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    multdiv_sequencer_if #(.CNT_W(6)) bus ();

    multdiv_sequencer #(
        .MULT_STEPS (16),
        .DIV_STEPS  (32),
        .CNT_W      (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {load_en, step_en, busy, data_resultRDY, data_exception, mode_div, step_idx}
    function automatic logic [11:0] obs();
        return {bus.load_en, bus.step_en, bus.busy, bus.data_resultRDY,
                bus.data_exception, bus.mode_div, bus.step_idx};
    endfunction

    task automatic test_reset();
        logic [11:0] got;
        reset = 1'b1;
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        bus.div_zero = 1'b0; bus.mult_ovf = 1'b0;
        repeat (2) @(negedge clock);
        got = obs();
        n_checks++;
        if (got !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", got, 12'b0);
        end
        reset = 1'b0;
        @(negedge clock);
        got = obs();
        n_checks++;
        if (got !== 12'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected %b", got, 12'b0);
        end
    endtask

    // Runs one operation from a start pulse and checks every cycle through
    // the cycle after DONE; n = steps, dz = divide-by-zero path.
    task automatic test_operation(input string name, input logic mul, input logic dv,
                                  input int n, input logic dz, input logic ovf,
                                  input logic exp_mode);
        logic [11:0] got, exp;
        logic        e_load, e_step, e_busy, e_rdy, e_exc;
        logic [5:0]  e_idx;
        int          done_c;
        done_c = dz ? 2 : n + 2;
        bus.div_zero = dz; bus.mult_ovf = ovf;
        bus.ctrl_MULT = mul; bus.ctrl_DIV = dv;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        for (int c = 1; c <= done_c + 1; c++) begin
            e_load = (c == 1);
            e_step = !dz && (c >= 2) && (c <= n + 1);
            e_busy = e_load || e_step;
            e_rdy  = (c == done_c);
            e_exc  = e_rdy && (dz || (!exp_mode && ovf));
            e_idx  = e_step ? 6'(c - 2) : 6'd0;
            exp = {e_load, e_step, e_busy, e_rdy, e_exc, exp_mode, e_idx};
            got = obs();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, exp);
            end
            @(negedge clock);
        end
        bus.div_zero = 1'b0; bus.mult_ovf = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [11:0] got;
        int          waited, rdy_seen;
        bus.ctrl_MULT = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        waited = 0;
        while (bus.step_idx !== 6'd7 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        n_checks++;
        if (bus.step_idx !== 6'd7) begin
            n_fail++;
            $display("FAIL reach_idx7: got %0d expected 7", bus.step_idx);
        end
        reset = 1'b1;
        #1;
        got = obs();
        n_checks++;
        if (got !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %b expected %b", got, 12'b0);
        end
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.data_resultRDY === 1'b1 || bus.busy !== 1'b0) rdy_seen++;
            @(negedge clock);
        end
        n_checks++;
        if (rdy_seen !== 0) begin
            n_fail++;
            $display("FAIL no_rdy_after_reset: got %0d active cycles expected 0", rdy_seen);
        end
    endtask

    task automatic test_restart();
        int waited, rdy_cnt, rdy_at;
        bus.ctrl_MULT = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        waited = 0;
        while (bus.step_idx !== 6'd10 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        bus.ctrl_DIV = 1'b1;
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        n_checks++;
        if ({bus.load_en, bus.mode_div, bus.step_idx} !== {1'b1, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL restart_load: got load=%b mode=%b idx=%0d expected load=1 mode=1 idx=0",
                     bus.load_en, bus.mode_div, bus.step_idx);
        end
        rdy_cnt = 0; rdy_at = -1;
        for (int c = 1; c <= 45; c++) begin
            if (bus.data_resultRDY === 1'b1) begin
                rdy_cnt++;
                rdy_at = c;
            end
            @(negedge clock);
        end
        n_checks++;
        if (rdy_cnt !== 1 || rdy_at !== 34) begin
            n_fail++;
            $display("FAIL restart_rdy: got %0d pulses last at cycle %0d expected 1 at cycle 34",
                     rdy_cnt, rdy_at);
        end
    endtask

    task automatic test_back_to_back();
        // A second ctrl_MULT during LOAD restarts the multiply; result timing
        // counts from the second pulse.
        logic [11:0] got;
        int          rdy_at;
        bus.ctrl_MULT = 1'b1;
        @(negedge clock);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        got = obs();
        n_checks++;
        if (got !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL b2b_reload: got %b expected %b", got, 12'b101000000000);
        end
        rdy_at = -1;
        for (int c = 1; c <= 25; c++) begin
            if (bus.data_resultRDY === 1'b1 && rdy_at < 0) rdy_at = c;
            @(negedge clock);
        end
        n_checks++;
        if (rdy_at !== 18) begin
            n_fail++;
            $display("FAIL b2b_rdy: got cycle %0d expected 18", rdy_at);
        end
    endtask

    initial begin
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        bus.div_zero = 1'b0; bus.mult_ovf = 1'b0;
        test_reset();
        test_reset_mid_run();
        test_operation("multiply",    1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0);
        test_operation("divide",      1'b0, 1'b1, 32, 1'b0, 1'b0, 1'b1);
        test_operation("div_by_zero", 1'b0, 1'b1, 32, 1'b1, 1'b0, 1'b1);
        test_operation("priority",    1'b1, 1'b1, 16, 1'b0, 1'b0, 1'b0);
        test_operation("mult_ovf",    1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0);
        test_operation("div_ignores_ovf", 1'b0, 1'b1, 32, 1'b0, 1'b1, 1'b1);
        test_restart();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
